// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the XNOR LFSR stream (x^N + x^TAP + 1).
// Hunts, syncs, locks, counts bit errors and packs locked data into words.
module lfsr_checker #(
  parameter int N           = 10,
  parameter int TAP         = 7,
  parameter int LOCK_CNT    = 16,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  output logic             locked,
  output logic [1:0]       state,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      word_out,
  output logic             word_valid
);

  localparam int FW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10,
    BAD    = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     sr_q, sr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      word_q, word_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             bit_err_q, bit_err_d;
  logic             wv_q, wv_d;

  logic             exp_bit;
  logic             match;
  logic [N-1:0]     sr_shift;
  logic [31:0]      shadow_n;
  logic [LW-1:0]    miss_n;

  // sr_q[0] is the newest bit, sr_q[N-1] the oldest
  assign exp_bit  = ~(sr_q[TAP-1] ^ sr_q[N-1]);
  assign match    = (din == exp_bit);
  assign sr_shift = {sr_q[N-2:0], din};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    fill_d    = fill_q;
    match_d   = match_q;
    miss_d    = miss_q;
    bit_idx_d = bit_idx_q;
    shadow_d  = shadow_q;
    word_d    = word_q;
    err_d     = err_q;
    bit_err_d = 1'b0;
    wv_d      = 1'b0;
    shadow_n  = shadow_q;
    shadow_n[5'd31 - bit_idx_q] = din;
    miss_n    = miss_q + LW'(!match);
    if (state_q == BAD) begin
      state_d = HUNT;
      fill_d  = '0;
    end else if (din_valid) begin
      sr_d = sr_shift;
      unique case (state_q)
        HUNT: begin
          if (fill_q == FW'(N - 1)) begin
            fill_d = '0;
            // all-ones is the XNOR lock-up state
            if (!(&sr_shift)) begin
              state_d = SYNC;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        SYNC: begin
          if (!match) begin
            match_d = '0;
          end else if (match_q == MW'(LOCK_CNT - 1)) begin
            state_d   = LOCKED;
            bit_idx_d = '0;
            miss_d    = '0;
            shadow_d  = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        LOCKED: begin
          if (!match) begin
            bit_err_d = 1'b1;
            if (err_q != '1) err_d = err_q + 1'b1;
          end
          if (miss_n == LW'(LOSS_THRESH)) begin
            state_d   = HUNT;
            fill_d    = '0;
            miss_d    = '0;
            bit_idx_d = '0;
            shadow_d  = '0;
          end else if (bit_idx_q == 5'd31) begin
            word_d    = shadow_n;
            wv_d      = 1'b1;
            bit_idx_d = '0;
            shadow_d  = '0;
            miss_d    = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shadow_d  = shadow_n;
            miss_d    = miss_n;
          end
        end
        default: begin
          state_d = HUNT;
          fill_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      bit_idx_q <= '0;
      shadow_q  <= '0;
      word_q    <= '0;
      err_q     <= '0;
      bit_err_q <= 1'b0;
      wv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      bit_idx_q <= bit_idx_d;
      shadow_q  <= shadow_d;
      word_q    <= word_d;
      err_q     <= err_d;
      bit_err_q <= bit_err_d;
      wv_q      <= wv_d;
    end
  end

  assign state      = state_q;
  assign locked     = (state_q == LOCKED);
  assign bit_err    = bit_err_q;
  assign err_count  = err_q;
  assign word_out   = word_q;
  assign word_valid = wv_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised bench for lfsr_checker against a bit-history reference model.
// Checks every cycle plus directed lock, word, error and loss scenarios.
module tb_lfsr_checker;

  localparam int N     = 10;
  localparam int TAP   = 7;
  localparam int LCNT  = 16;
  localparam int LOSS  = 4;
  localparam int ERR_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             din;
  logic             din_valid;
  logic             locked;
  logic [1:0]       state;
  logic             bit_err;
  logic [ERR_W-1:0] err_count;
  logic [31:0]      word_out;
  logic             word_valid;

  always #5 clk = ~clk;

  lfsr_checker #(
    .N(N), .TAP(TAP), .LOCK_CNT(LCNT),
    .LOSS_THRESH(LOSS), .ERR_W(ERR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .din_valid(din_valid),
    .locked(locked),
    .state(state),
    .bit_err(bit_err),
    .err_count(err_count),
    .word_out(word_out),
    .word_valid(word_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: full history of accepted bits since reset
  bit          hist[$];
  bit          wq[$];
  int          m_state, m_fill, m_match, m_miss, m_err;
  logic [31:0] m_word;
  bit          m_berr, m_wv;

  // generator history
  bit g[$];

  function automatic bit hb(int k);
    return (k < 0) ? 1'b0 : hist[k];
  endfunction

  function automatic bit gb(int k);
    return (k < 0) ? 1'b0 : g[k];
  endfunction

  function automatic bit model_exp();
    int n = hist.size();
    return ~(hb(n - TAP) ^ hb(n - N));
  endfunction

  function automatic bit gen_next();
    int n = g.size();
    bit b = ~(gb(n - 7) ^ gb(n - 10));
    g.push_back(b);
    return b;
  endfunction

  task automatic model_reset();
    hist.delete();
    wq.delete();
    m_state = 0; m_fill = 0; m_match = 0;
    m_miss = 0;  m_err = 0;  m_word = '0;
  endtask

  task automatic model_step(input bit d);
    bit e, mt, all1;
    e  = model_exp();
    mt = (d == e);
    hist.push_back(d);
    case (m_state)
      0: begin
        m_fill++;
        if (m_fill == N) begin
          all1 = 1'b1;
          for (int k = 1; k <= N; k++)
            all1 &= hist[hist.size() - k];
          if (all1) m_fill = 0;
          else begin
            m_state = 1;
            m_match = 0;
          end
        end
      end
      1: begin
        if (mt) begin
          m_match++;
          if (m_match == LCNT) begin
            m_state = 2;
            wq.delete();
            m_miss = 0;
          end
        end else m_match = 0;
      end
      default: begin
        wq.push_back(d);
        if (!mt) begin
          m_berr = 1'b1;
          if (m_err < (2 ** ERR_W) - 1) m_err++;
          m_miss++;
        end
        if (m_miss == LOSS) begin
          m_state = 0;
          m_fill  = 0;
          wq.delete();
        end else if (wq.size() == 32) begin
          for (int k = 0; k < 32; k++) m_word[31 - k] = wq[k];
          m_wv = 1'b1;
          wq.delete();
          m_miss = 0;
        end
      end
    endcase
  endtask

  task automatic cycle(input bit r, input bit v, input bit d);
    reset = r; din_valid = v; din = d;
    @(posedge clk);
    m_berr = 1'b0;
    m_wv   = 1'b0;
    if (!r) model_reset();
    else if (v) model_step(d);
    #1;
    chk("state", state, m_state);
    chk("locked", locked, (m_state == 2));
    chk("bit_err", bit_err, m_berr);
    chk("word_valid", word_valid, m_wv);
    chk("err_count", err_count, m_err);
    chk("word_out", word_out, m_word);
  endtask

  initial begin
    int wvc, e0, vc, maxs;
    logic [31:0] w;
    bit b;
    model_reset();
    m_berr = 0; m_wv = 0;

    // reset hold with valid data present
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1);
    chk("rst_state", state, 0);
    chk("rst_word", word_out, 0);

    // clean lock from all-zero seed
    g.delete();
    for (int i = 1; i <= 26; i++) begin
      cycle(1'b1, 1'b1, gen_next());
      if (i == 10) chk("sync_at10", state, 1);
      if (i == 25) chk("nolock_at25", locked, 0);
      if (i == 26) chk("lock_at26", locked, 1);
    end
    chk("lock_err0", err_count, 0);

    // two clean words
    wvc = 0; w = '0;
    for (int i = 0; i < 64; i++) begin
      b = gen_next();
      w = {w[30:0], b};
      cycle(1'b1, 1'b1, b);
      if (word_valid) wvc++;
      if (i % 32 == 31) begin
        chk("wv_pulse", word_valid, 1);
        chk("word_bits", word_out, w);
      end
    end
    chk("wv_count", wvc, 2);

    // single inverted bit gives three mismatches
    e0 = err_count;
    cycle(1'b1, 1'b1, ~gen_next());
    chk("err_pulse", bit_err, 1);
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, gen_next());
    chk("err_total3", err_count - e0, 3);
    chk("still_locked", locked, 1);

    // loss of lock: ones, then forced mismatches if still locked
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20 && m_state == 2; i++)
      cycle(1'b1, 1'b1, ~model_exp());
    chk("lost_state", state, 0);
    chk("lost_locked", locked, 0);
    maxs = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b1, 1'b1);
      if (int'(state) > maxs) maxs = state;
    end
    chk("hunt_ones", maxs, 0);

    // valid gaps during fill/sync
    cycle(1'b0, 1'b1, 1'b0);
    g.delete();
    vc = 0;
    for (int i = 0; i < 400 && vc < 26; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        vc++;
        cycle(1'b1, 1'b1, gen_next());
        if (vc == 25) chk("gap_nolock25", locked, 0);
        if (vc == 26) chk("gap_lock26", locked, 1);
      end else begin
        cycle(1'b1, 1'b0, 1'($urandom));
      end
    end
    chk("gap_vcount", vc, 26);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, gen_next());

    // mid-lock reset
    cycle(1'b0, 1'b1, 1'b1);
    chk("mr_state", state, 0);
    chk("mr_locked", locked, 0);
    chk("mr_err", err_count, 0);
    chk("mr_word", word_out, 0);

    // random traffic: gaps, sparse errors, random bursts
    g.delete();
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 150) begin
        for (int k = 0; k < 20; k++)
          cycle(1'b1, 1'b1, 1'($urandom));
      end else if ($urandom_range(3, 0) != 0) begin
        b = gen_next();
        if ($urandom_range(39, 0) == 0) b = ~b;
        cycle(1'b1, 1'b1, b);
      end else begin
        cycle(1'b1, 1'b0, 1'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
